// File: rtl/sm4_key_ctrl.sv
// SM4 key-schedule controller: hands the master key to the expansion pipeline,
// banks the 32 returned round keys and streams them in encrypt or decrypt order.
//   state  | meaning
//   IDLE   | no valid schedule, ready for a key
//   EXPAND | waiting for RK_READY_i, bounded by TIMEOUT
//   LOADED | bank holds a schedule, ready for a key or a stream request
//   STREAM | emitting 32 consecutive round keys
module sm4_key_ctrl #(
    parameter int TIMEOUT = 40
) (
    input  logic          CLK_i,
    input  logic          RST_N_i,
    input  logic [127:0]  KEY_i,
    input  logic          KEY_VALID_i,
    output logic          KEY_READY_o,
    output logic [127:0]  MK_o,
    output logic          MK_VALID_o,
    input  logic [1023:0] RK_i,
    input  logic          RK_READY_i,
    input  logic          RK_REQ_i,
    input  logic          DEC_i,
    output logic [31:0]   RK_o,
    output logic          RK_VALID_o,
    output logic          RK_LAST_o,
    output logic          KEY_LOADED_o,
    output logic          ERR_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        LOADED = 2'd2,
        STREAM = 2'd3
    } state_t;

    localparam logic [5:0] LAST_WAIT = 6'(TIMEOUT - 1);

    state_t      state;
    logic [5:0]  wait_cnt;
    logic [4:0]  idx;
    logic        dec_lat;
    logic [31:0] bank [32];
    logic        key_xfer;
    logic        bank_wr;

    assign KEY_READY_o = (state == IDLE) || (state == LOADED);
    assign key_xfer    = KEY_VALID_i & KEY_READY_o;
    assign bank_wr     = RST_N_i && (state == EXPAND) && RK_READY_i;

    always_ff @(posedge CLK_i) begin
        if (!RST_N_i) begin
            state        <= IDLE;
            MK_o         <= '0;
            MK_VALID_o   <= 1'b0;
            RK_o         <= '0;
            RK_VALID_o   <= 1'b0;
            RK_LAST_o    <= 1'b0;
            KEY_LOADED_o <= 1'b0;
            ERR_o        <= 1'b0;
            wait_cnt     <= '0;
            idx          <= '0;
            dec_lat      <= 1'b0;
        end else begin
            MK_VALID_o <= 1'b0;
            RK_VALID_o <= 1'b0;
            RK_LAST_o  <= 1'b0;
            // A key load outranks a stream request arriving in the same LOADED cycle.
            if (key_xfer) begin
                MK_o         <= KEY_i;
                MK_VALID_o   <= 1'b1;
                wait_cnt     <= '0;
                KEY_LOADED_o <= 1'b0;
                ERR_o        <= 1'b0;
                state        <= EXPAND;
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    EXPAND: begin
                        if (wait_cnt != 6'd63) begin
                            wait_cnt <= wait_cnt + 6'd1;
                        end
                        if (RK_READY_i) begin
                            KEY_LOADED_o <= 1'b1;
                            state        <= LOADED;
                        end else if (wait_cnt == LAST_WAIT) begin
                            ERR_o <= 1'b1;
                            state <= IDLE;
                        end
                    end
                    LOADED: begin
                        if (RK_REQ_i) begin
                            dec_lat <= DEC_i;
                            idx     <= '0;
                            state   <= STREAM;
                        end
                    end
                    STREAM: begin
                        // For a 5-bit index, 31-idx is simply its complement.
                        RK_o       <= bank[dec_lat ? ~idx : idx];
                        RK_VALID_o <= 1'b1;
                        RK_LAST_o  <= (idx == 5'd31);
                        idx        <= idx + 5'd1;
                        if (idx == 5'd31) begin
                            state <= LOADED;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CLK_i) begin
        if (bank_wr) begin
            for (int i = 0; i < 32; i++) begin
                bank[i] <= RK_i[1023 - 32*i -: 32];
            end
        end
    end

endmodule

// File: tb/tb_sm4_key_ctrl.sv
// Directed bench for sm4_key_ctrl: key load, both stream orders, timeout,
// load/request collision and resets in the middle of EXPAND and STREAM.
module tb_sm4_key_ctrl;

    logic          CLK_i = 1'b0;
    logic          RST_N_i;
    logic [127:0]  KEY_i;
    logic          KEY_VALID_i;
    logic          KEY_READY_o;
    logic [127:0]  MK_o;
    logic          MK_VALID_o;
    logic [1023:0] RK_i;
    logic          RK_READY_i;
    logic          RK_REQ_i;
    logic          DEC_i;
    logic [31:0]   RK_o;
    logic          RK_VALID_o;
    logic          RK_LAST_o;
    logic          KEY_LOADED_o;
    logic          ERR_o;

    int errors = 0;
    int checks = 0;

    logic [31:0]   exp_rk [32];
    logic [1023:0] rk_vec;
    logic [127:0]  key_a;
    logic [127:0]  key_b;

    sm4_key_ctrl #(.TIMEOUT(40)) dut (
        .CLK_i(CLK_i), .RST_N_i(RST_N_i), .KEY_i(KEY_i), .KEY_VALID_i(KEY_VALID_i),
        .KEY_READY_o(KEY_READY_o), .MK_o(MK_o), .MK_VALID_o(MK_VALID_o),
        .RK_i(RK_i), .RK_READY_i(RK_READY_i), .RK_REQ_i(RK_REQ_i), .DEC_i(DEC_i),
        .RK_o(RK_o), .RK_VALID_o(RK_VALID_o), .RK_LAST_o(RK_LAST_o),
        .KEY_LOADED_o(KEY_LOADED_o), .ERR_o(ERR_o)
    );

    always #5 CLK_i = ~CLK_i;

    task automatic tick();
        @(posedge CLK_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Deliver the round-key vector to a controller currently in EXPAND.
    task automatic deliver_rk(input logic [1023:0] vec);
        RK_i = vec;
        RK_READY_i = 1'b1;
        tick();
        RK_READY_i = 1'b0;
        RK_i = '0;
    endtask

    task automatic test_reset();
        RST_N_i = 1'b0;
        tick();
        tick();
        RST_N_i = 1'b1;
        checks++; if (KEY_READY_o !== 1'b1) begin errors++; $display("FAIL reset_key_ready: got %b expected 1", KEY_READY_o); end
        checks++; if (MK_VALID_o !== 1'b0) begin errors++; $display("FAIL reset_mk_valid: got %b expected 0", MK_VALID_o); end
        checks++; if (MK_o !== 128'h0) begin errors++; $display("FAIL reset_mk: got %h expected 0", MK_o); end
        checks++; if (RK_o !== 32'h0) begin errors++; $display("FAIL reset_rk: got %h expected 0", RK_o); end
        checks++; if ({RK_VALID_o, RK_LAST_o, KEY_LOADED_o, ERR_o} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b expected 0000", {RK_VALID_o, RK_LAST_o, KEY_LOADED_o, ERR_o});
        end
        RK_REQ_i = 1'b1;
        tick();
        RK_REQ_i = 1'b0;
        tick();
        checks++; if (RK_VALID_o !== 1'b0) begin errors++; $display("FAIL idle_req_ignored: got %b expected 0", RK_VALID_o); end
    endtask

    task automatic test_key_load();
        KEY_i = key_a;
        KEY_VALID_i = 1'b1;
        tick();
        KEY_VALID_i = 1'b0;
        checks++; if (MK_VALID_o !== 1'b1) begin errors++; $display("FAIL load_mk_valid: got %b expected 1", MK_VALID_o); end
        checks++; if (MK_o !== key_a) begin errors++; $display("FAIL load_mk: got %h expected %h", MK_o, key_a); end
        checks++; if (KEY_READY_o !== 1'b0) begin errors++; $display("FAIL load_not_ready: got %b expected 0", KEY_READY_o); end
        tick();
        checks++; if (MK_VALID_o !== 1'b0) begin errors++; $display("FAIL load_mk_pulse: got %b expected 0", MK_VALID_o); end
        for (int i = 0; i < 30; i++) tick();
        checks++; if (KEY_LOADED_o !== 1'b0) begin errors++; $display("FAIL load_early: got %b expected 0", KEY_LOADED_o); end
        deliver_rk(rk_vec);
        checks++; if (KEY_LOADED_o !== 1'b1) begin errors++; $display("FAIL load_loaded: got %b expected 1", KEY_LOADED_o); end
        checks++; if (KEY_READY_o !== 1'b1) begin errors++; $display("FAIL load_ready: got %b expected 1", KEY_READY_o); end
        checks++; if (ERR_o !== 1'b0) begin errors++; $display("FAIL load_err: got %b expected 0", ERR_o); end
    endtask

    task automatic run_stream(input string name, input logic dec, input logic disturb);
        logic [31:0] want;
        DEC_i = dec;
        RK_REQ_i = 1'b1;
        tick();
        RK_REQ_i = 1'b0;
        checks++; if (RK_VALID_o !== 1'b0) begin errors++; $display("FAIL %s_entry_valid: got %b expected 0", name, RK_VALID_o); end
        for (int i = 0; i < 32; i++) begin
            if (disturb) begin
                DEC_i = (i % 3 == 1) ? ~dec : dec;
                RK_REQ_i = (i == 10);
            end
            tick();
            want = dec ? exp_rk[31 - i] : exp_rk[i];
            checks++; if (RK_VALID_o !== 1'b1) begin errors++; $display("FAIL %s_valid[%0d]: got %b expected 1", name, i, RK_VALID_o); end
            checks++; if (RK_o !== want) begin errors++; $display("FAIL %s_rk[%0d]: got %h expected %h", name, i, RK_o, want); end
            checks++; if (RK_LAST_o !== (i == 31)) begin errors++; $display("FAIL %s_last[%0d]: got %b expected %b", name, i, RK_LAST_o, (i == 31)); end
        end
        RK_REQ_i = 1'b0;
        DEC_i = 1'b0;
        checks++; if (KEY_READY_o !== 1'b1) begin errors++; $display("FAIL %s_back_loaded: got %b expected 1", name, KEY_READY_o); end
        tick();
        want = dec ? exp_rk[0] : exp_rk[31];
        checks++; if ({RK_VALID_o, RK_LAST_o} !== 2'b00) begin errors++; $display("FAIL %s_after_flags: got %b expected 00", name, {RK_VALID_o, RK_LAST_o}); end
        checks++; if (RK_o !== want) begin errors++; $display("FAIL %s_rk_hold: got %h expected %h", name, RK_o, want); end
    endtask

    task automatic test_encrypt();
        run_stream("enc", 1'b0, 1'b0);
    endtask

    task automatic test_decrypt();
        run_stream("dec", 1'b1, 1'b1);
    endtask

    task automatic test_ready_ignored();
        RK_i = '0;
        RK_READY_i = 1'b1;
        tick();
        tick();
        RK_READY_i = 1'b0;
        checks++; if (KEY_LOADED_o !== 1'b1) begin errors++; $display("FAIL stray_ready_loaded: got %b expected 1", KEY_LOADED_o); end
        run_stream("enc2", 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        KEY_i = key_b;
        KEY_VALID_i = 1'b1;
        tick();
        KEY_VALID_i = 1'b0;
        for (int i = 0; i < 39; i++) tick();
        checks++; if (ERR_o !== 1'b0) begin errors++; $display("FAIL timeout_early_err: got %b expected 0", ERR_o); end
        checks++; if (KEY_READY_o !== 1'b0) begin errors++; $display("FAIL timeout_early_state: got %b expected 0", KEY_READY_o); end
        tick();
        checks++; if (ERR_o !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b expected 1", ERR_o); end
        checks++; if (KEY_READY_o !== 1'b1) begin errors++; $display("FAIL timeout_idle: got %b expected 1", KEY_READY_o); end
        checks++; if (KEY_LOADED_o !== 1'b0) begin errors++; $display("FAIL timeout_loaded: got %b expected 0", KEY_LOADED_o); end
        deliver_rk(rk_vec);
        checks++; if (KEY_LOADED_o !== 1'b0) begin errors++; $display("FAIL timeout_late_ready: got %b expected 0", KEY_LOADED_o); end
        checks++; if (ERR_o !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b expected 1", ERR_o); end
        KEY_i = key_a;
        KEY_VALID_i = 1'b1;
        tick();
        KEY_VALID_i = 1'b0;
        checks++; if (ERR_o !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b expected 0", ERR_o); end
        checks++; if (MK_VALID_o !== 1'b1) begin errors++; $display("FAIL timeout_reload: got %b expected 1", MK_VALID_o); end
        deliver_rk(rk_vec);
        checks++; if (KEY_LOADED_o !== 1'b1) begin errors++; $display("FAIL timeout_reloaded: got %b expected 1", KEY_LOADED_o); end
    endtask

    task automatic test_collision();
        KEY_i = key_b;
        KEY_VALID_i = 1'b1;
        RK_REQ_i = 1'b1;
        DEC_i = 1'b0;
        tick();
        KEY_VALID_i = 1'b0;
        RK_REQ_i = 1'b0;
        checks++; if (MK_VALID_o !== 1'b1) begin errors++; $display("FAIL coll_mk_valid: got %b expected 1", MK_VALID_o); end
        checks++; if (MK_o !== key_b) begin errors++; $display("FAIL coll_mk: got %h expected %h", MK_o, key_b); end
        checks++; if (KEY_LOADED_o !== 1'b0) begin errors++; $display("FAIL coll_loaded: got %b expected 0", KEY_LOADED_o); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (RK_VALID_o !== 1'b0) begin errors++; $display("FAIL coll_no_stream[%0d]: got %b expected 0", i, RK_VALID_o); end
        end
        checks++; if (KEY_LOADED_o !== 1'b0) begin errors++; $display("FAIL coll_still_unloaded: got %b expected 0", KEY_LOADED_o); end
        deliver_rk(rk_vec);
        checks++; if (KEY_LOADED_o !== 1'b1) begin errors++; $display("FAIL coll_loaded_after: got %b expected 1", KEY_LOADED_o); end
    endtask

    task automatic test_reset_mid_stream();
        DEC_i = 1'b0;
        RK_REQ_i = 1'b1;
        tick();
        RK_REQ_i = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        checks++; if (RK_o !== exp_rk[9]) begin errors++; $display("FAIL rst_stream_pre: got %h expected %h", RK_o, exp_rk[9]); end
        RST_N_i = 1'b0;
        tick();
        checks++; if (RK_VALID_o !== 1'b0) begin errors++; $display("FAIL rst_stream_valid: got %b expected 0", RK_VALID_o); end
        checks++; if (KEY_LOADED_o !== 1'b0) begin errors++; $display("FAIL rst_stream_loaded: got %b expected 0", KEY_LOADED_o); end
        RST_N_i = 1'b1;
        checks++; if (KEY_READY_o !== 1'b1) begin errors++; $display("FAIL rst_stream_ready: got %b expected 1", KEY_READY_o); end
        tick();
        checks++; if (RK_VALID_o !== 1'b0) begin errors++; $display("FAIL rst_stream_quiet: got %b expected 0", RK_VALID_o); end
    endtask

    task automatic test_reset_mid_expand();
        KEY_i = key_a;
        KEY_VALID_i = 1'b1;
        tick();
        KEY_VALID_i = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        RST_N_i = 1'b0;
        tick();
        RST_N_i = 1'b1;
        checks++; if (KEY_READY_o !== 1'b1) begin errors++; $display("FAIL rst_exp_ready: got %b expected 1", KEY_READY_o); end
        deliver_rk(rk_vec);
        checks++; if (KEY_LOADED_o !== 1'b0) begin errors++; $display("FAIL rst_exp_ready_ignored: got %b expected 0", KEY_LOADED_o); end
        checks++; if ({MK_VALID_o, ERR_o} !== 2'b00) begin errors++; $display("FAIL rst_exp_flags: got %b expected 00", {MK_VALID_o, ERR_o}); end
    endtask

    initial begin
        key_a = 128'h0123456789ABCDEFFEDCBA9876543210;
        key_b = 128'hDEADBEEF0000111122223333CAFEF00D;
        for (int i = 0; i < 32; i++) begin
            exp_rk[i] = {8'hC3, 8'(i), 8'h5A, ~8'(i)};
        end
        exp_rk[0]  = 32'hF12186F9;
        exp_rk[31] = 32'h9124A012;
        rk_vec = '0;
        for (int i = 0; i < 32; i++) begin
            rk_vec[1023 - 32*i -: 32] = exp_rk[i];
        end
        RST_N_i = 1'b0;
        KEY_i = '0;
        KEY_VALID_i = 1'b0;
        RK_i = '0;
        RK_READY_i = 1'b0;
        RK_REQ_i = 1'b0;
        DEC_i = 1'b0;

        test_reset();
        test_key_load();
        test_encrypt();
        test_decrypt();
        test_ready_ignored();
        test_timeout();
        test_collision();
        test_reset_mid_stream();
        test_reset_mid_expand();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
